// File: rtl/dma_read_scheduler_if.sv
// Descriptor-intake and DMA-engine signals of the read scheduler, bundled as one port.
// Latency: none; wiring only.
// Backpressure: desc_valid/desc_ready on the descriptor side, dma_done level/pulse on the engine side.
interface dma_read_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_addr;
  logic [LEN_W-1:0]  desc_len;

  logic              dma_start;
  logic [ADDR_W-1:0] dma_base_addr;
  logic [LEN_W-1:0]  dma_length;
  logic              dma_done;

  // Scheduler side: sinks descriptors, drives the DMA engine.
  modport master (
    input  desc_valid, desc_addr, desc_len, dma_done,
    output desc_ready, dma_start, dma_base_addr, dma_length
  );

  // Environment side: descriptor source plus DMA engine.
  modport slave (
    output desc_valid, desc_addr, desc_len, dma_done,
    input  desc_ready, dma_start, dma_base_addr, dma_length
  );
endinterface

// File: rtl/dma_read_scheduler.sv
// Queues DMA read descriptors in a small FIFO and issues them one at a time to the read engine.
// Latency: descriptor pushed at edge k into an empty idle queue is popped at k+1; dma_start high k+1..k+2.
// Backpressure: desc_ready drops when the FIFO is full or flush is high; dma_done must fall before the next issue.
module dma_read_scheduler #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dma_read_scheduler_if.master     bus,
  input  logic                     flush,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [CNT_W-1:0]         done_count,
  output logic                     all_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int QW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  desc_t             fifo_q [DEPTH];
  desc_t             fifo_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [QW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
  logic              pending_q, pending_d;

  logic              desc_ready_int;
  logic              push;
  logic              pop;
  logic              all_done_int;
  desc_t             head;

  // A full FIFO refuses pushes even when a pop is happening at the same edge.
  assign desc_ready_int = (count_q < QW'(DEPTH)) && !flush;
  assign push           = bus.desc_valid && desc_ready_int;
  // Flush wins over an idle pop: the head is discarded rather than issued.
  assign pop            = (state_q == IDLE) && (count_q != '0) && !flush;
  assign head           = fifo_q[rd_ptr_q];
  // pending marks completed work not yet reported; it clears on the edge where the pulse shows.
  assign all_done_int   = (state_q == IDLE) && (count_q == '0) && pending_q;

  assign bus.desc_ready    = desc_ready_int;
  assign bus.dma_start     = (state_q == START);
  assign bus.dma_base_addr = addr_q;
  assign bus.dma_length    = len_q;
  assign busy              = (state_q != IDLE) || (count_q != '0);
  assign queue_count       = count_q;
  assign done_count        = done_cnt_q;
  assign all_done          = all_done_int;

  // FIFO next state: push at the tail, pop at the head, flush empties everything.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = '{addr: bus.desc_addr, len: bus.desc_len};
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + QW'(push) - QW'(pop);
    end
  end

  // Issue FSM: latch a descriptor on pop, pulse start, count one completion per dma_done episode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    done_cnt_d = done_cnt_q;
    pending_d  = all_done_int ? 1'b0 : pending_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          addr_d = head.addr;
          len_d  = head.len;
          if (head.len == '0) begin
            // Nothing to move: retire it here without touching the engine.
            done_cnt_d = done_cnt_q + CNT_W'(1);
            pending_d  = 1'b1;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.dma_done) begin
          done_cnt_d = done_cnt_q + CNT_W'(1);
          pending_d  = 1'b1;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        // A held done must drop before the next descriptor may start.
        if (!bus.dma_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers and count define validity.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // Control state register with asynchronous reset that abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      done_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      done_cnt_q <= done_cnt_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_dma_read_scheduler.sv
// Bench for dma_read_scheduler: directed scenarios plus randomized traffic against a queue-based model.
// Latency: outputs checked every cycle on the falling edge, after the rising edge they follow.
// Backpressure: descriptor pushes hold desc_valid until accepted; a stub engine answers dma_start.
module tb_dma_read_scheduler;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              busy;
  logic [2:0]        queue_count;
  logic [CNT_W-1:0]  done_count;
  logic              all_done;

  dma_read_scheduler_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  dma_read_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush       (flush),
    .busy        (busy),
    .queue_count (queue_count),
    .done_count  (done_count),
    .all_done    (all_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model: descriptor queue plus one transfer slot ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [15:0] l;
  } d_t;

  d_t          mq[$];
  bit          m_xfer;     // a transfer owns the engine
  bit          m_start;    // the transfer was issued at the last edge
  bit          m_counted;  // its completion was counted, waiting for done to drop
  bit          m_pending;
  logic [15:0] m_cnt;
  logic [31:0] m_addr;
  logic [15:0] m_len;

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && !flush;
  endfunction

  function automatic bit m_all_done();
    return !m_xfer && (mq.size() == 0) && m_pending;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_xfer = 0; m_start = 0; m_counted = 0; m_pending = 0;
    m_cnt = '0; m_addr = '0; m_len = '0;
  endtask

  task automatic model_edge();
    bit rdy, push;
    d_t d;
    rdy  = m_ready();
    push = bus.desc_valid && rdy;
    if (m_all_done()) m_pending = 0;
    if (!m_xfer) begin
      if (mq.size() != 0 && !flush) begin
        d = mq.pop_front();
        m_addr = d.a;
        m_len  = d.l;
        if (d.l == 0) begin
          m_cnt++;
          m_pending = 1;
        end else begin
          m_xfer = 1; m_start = 1; m_counted = 0;
        end
      end
    end else if (m_start) begin
      m_start = 0;
    end else if (!m_counted) begin
      if (bus.dma_done) begin
        m_cnt++;
        m_pending = 1;
        m_counted = 1;
      end
    end else if (!bus.dma_done) begin
      m_xfer = 0;
    end
    if (flush) mq.delete();
    else if (push) begin
      d.a = bus.desc_addr;
      d.l = bus.desc_len;
      mq.push_back(d);
    end
  endtask

  task automatic check_all();
    check_eq("desc_ready",    64'(bus.desc_ready),    64'(m_ready()));
    check_eq("dma_start",     64'(bus.dma_start),     64'(m_start));
    check_eq("dma_base_addr", 64'(bus.dma_base_addr), 64'(m_addr));
    check_eq("dma_length",    64'(bus.dma_length),    64'(m_len));
    check_eq("busy",          64'(busy),              64'(m_xfer || mq.size() != 0));
    check_eq("queue_count",   64'(queue_count),       64'(mq.size()));
    check_eq("done_count",    64'(done_count),        64'(m_cnt));
    check_eq("all_done",      64'(all_done),          64'(m_all_done()));
  endtask

  // ---------------- stub DMA engine ----------------
  int s_dly = 5, s_hold = 1, s_del = 0, s_h = 0;
  bit seen_start = 0, noise = 0, rnd_stub = 0;

  task automatic drive_stub();
    if (seen_start) begin
      if (rnd_stub) begin
        s_del = $urandom_range(1, 6);
        s_h   = $urandom_range(1, 4);
      end else begin
        s_del = s_dly;
        s_h   = s_hold;
      end
    end
    if (s_del > 0) begin
      s_del--;
      bus.dma_done = 1'b0;
    end else if (s_h > 0) begin
      s_h--;
      bus.dma_done = 1'b1;
    end else begin
      bus.dma_done = noise && ($urandom_range(0, 19) == 0);
    end
  endtask

  // ---------------- cycle machinery and observation ----------------
  int          cyc = 0, n_start = 0, n_alldone = 0;
  logic [31:0] start_addr[$];
  logic [15:0] start_len[$];
  int          start_cyc[$];

  task automatic clear_stats();
    n_start = 0; n_alldone = 0;
    start_addr.delete(); start_len.delete(); start_cyc.delete();
  endtask

  task automatic cycle();
    drive_stub();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_all();
    seen_start = bus.dma_start;
    if (bus.dma_start) begin
      n_start++;
      start_addr.push_back(bus.dma_base_addr);
      start_len.push_back(bus.dma_length);
      start_cyc.push_back(cyc);
    end
    if (all_done) n_alldone++;
  endtask

  task automatic send(input logic [31:0] a, input logic [15:0] l);
    bit acc;
    acc = 0;
    bus.desc_valid = 1'b1;
    bus.desc_addr  = a;
    bus.desc_len   = l;
    for (int i = 0; i < 300; i++) begin
      #1;
      acc = bus.desc_ready;
      cycle();
      if (acc) break;
    end
    check_eq("send_accepted", 64'(acc), 64'(1));
    bus.desc_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && (busy || all_done); i++) cycle();
    check_eq("drain_idle", 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check_eq("rst_done_count", 64'(done_count),        64'(0));
    check_eq("rst_queue",      64'(queue_count),       64'(0));
    check_eq("rst_busy",       64'(busy),              64'(0));
    check_eq("rst_start",      64'(bus.dma_start),     64'(0));
    check_eq("rst_addr",       64'(bus.dma_base_addr), 64'(0));
    check_eq("rst_len",        64'(bus.dma_length),    64'(0));
    check_eq("rst_all_done",   64'(all_done),          64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.desc_valid = 1'b0;
    bus.desc_addr  = '0;
    bus.desc_len   = '0;
    bus.dma_done   = 1'b0;
    model_reset();
    #1;
    check_all();
    check_eq("init_ready", 64'(bus.desc_ready), 64'(1));
    check_eq("init_busy",  64'(busy),           64'(0));
    check_eq("init_queue", 64'(queue_count),    64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single descriptor, done pulse 40 cycles after start.
    clear_stats(); s_dly = 40; s_hold = 1;
    send(32'h0, 16'd32);
    wait_drain(200);
    check_eq("single_starts",   64'(n_start),       64'(1));
    check_eq("single_addr",     64'(start_addr[0]), 64'(32'h0));
    check_eq("single_len",      64'(start_len[0]),  64'(32));
    check_eq("single_done_cnt", 64'(done_count),    64'(1));
    check_eq("single_all_done", 64'(n_alldone),     64'(1));

    // Back-pressure: five back-to-back pushes while the engine stalls.
    clear_stats(); s_dly = 30;
    for (int i = 0; i < 5; i++) send(32'(i * 32), 16'd64);
    check_eq("bp_queue_full", 64'(queue_count),    64'(4));
    check_eq("bp_ready_low",  64'(bus.desc_ready), 64'(0));
    wait_drain(1000);
    check_eq("bp_starts", 64'(n_start), 64'(5));
    for (int i = 0; i < 5; i++) check_eq("bp_order", 64'(start_addr[i]), 64'(i * 32));
    check_eq("bp_done_cnt", 64'(done_count), 64'(6));
    check_eq("bp_all_done", 64'(n_alldone),  64'(1));

    // Zero-length descriptor is retired without engine activity.
    clear_stats(); s_dly = 5;
    send(32'h100, 16'd0);
    send(32'h200, 16'd16);
    check_eq("zl_step", 64'(done_count), 64'(7));
    wait_drain(200);
    check_eq("zl_starts",   64'(n_start),       64'(1));
    check_eq("zl_addr",     64'(start_addr[0]), 64'(32'h200));
    check_eq("zl_len",      64'(start_len[0]),  64'(16));
    check_eq("zl_done_cnt", 64'(done_count),    64'(8));
    check_eq("zl_all_done", 64'(n_alldone),     64'(1));

    // Held done: three-cycle level counts once, next start waits for it to fall.
    clear_stats(); s_dly = 5; s_hold = 3;
    send(32'h400, 16'd8);
    send(32'h480, 16'd8);
    wait_drain(200);
    check_eq("hd_starts",   64'(n_start),                    64'(2));
    check_eq("hd_addr1",    64'(start_addr[1]),              64'(32'h480));
    check_eq("hd_gap",      64'(start_cyc[1] - start_cyc[0]), 64'(10));
    check_eq("hd_done_cnt", 64'(done_count),                 64'(10));
    check_eq("hd_all_done", 64'(n_alldone),                  64'(1));

    // Flush: three queued behind an active transfer are dropped.
    clear_stats(); s_dly = 20; s_hold = 1;
    for (int i = 0; i < 4; i++) send(32'h1000 + 32'(i * 64), 16'd32);
    check_eq("fl_pre_queue", 64'(queue_count), 64'(3));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check_eq("fl_queue", 64'(queue_count), 64'(0));
    wait_drain(200);
    check_eq("fl_starts",   64'(n_start),    64'(1));
    check_eq("fl_done_cnt", 64'(done_count), 64'(11));
    check_eq("fl_all_done", 64'(n_alldone),  64'(1));

    // Reset during WAIT with two queued; late done must be ignored.
    clear_stats(); s_dly = 20;
    send(32'h2000, 16'd16);
    send(32'h2040, 16'd16);
    send(32'h2080, 16'd16);
    for (int i = 0; i < 3; i++) cycle();
    do_reset();
    clear_stats();
    for (int i = 0; i < 30; i++) cycle();
    check_eq("rm_late_done", 64'(done_count), 64'(0));
    check_eq("rm_no_start",  64'(n_start),    64'(0));
    s_dly = 3;
    send(32'h300, 16'd8);
    wait_drain(200);
    check_eq("rm_addr",     64'(start_addr[0]), 64'(32'h300));
    check_eq("rm_done_cnt", 64'(done_count),    64'(1));
    check_eq("rm_all_done", 64'(n_alldone),     64'(1));

    // Randomized traffic with spurious done, random flush and one reset.
    noise = 1; rnd_stub = 1;
    for (int i = 0; i < 2500; i++) begin
      bus.desc_valid = ($urandom_range(0, 2) == 0);
      bus.desc_addr  = $urandom;
      bus.desc_len   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 4096));
      flush          = ($urandom_range(0, 39) == 0);
      if (i == 1200) do_reset();
      cycle();
    end
    bus.desc_valid = 1'b0;
    flush = 1'b0;
    noise = 0;
    wait_drain(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_read_scheduler.md
Name: dma_read_scheduler

Overview:
- Descriptor-queue controller that sequences the memory-to-AXIS DMA read engine (start / base_addr / length / done interface).
- Accepts read descriptors (address, byte length) from a control source into a small FIFO, then issues them one at a time.
- Holds the DMA address and length stable for the whole of each transfer, counts completions, and raises a pulse when all queued work has drained.
- Sits between the control/CPU-side sequencer and the DMA read engine, so that weight and activation loads can be queued back-to-back.

Parameters:
- DEPTH, 4, descriptor FIFO entries; power of 2, minimum 2.
- ADDR_W, 32, descriptor / DMA base address width.
- LEN_W, 16, descriptor / DMA length width, in bytes.
- CNT_W, 16, completion counter width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  descriptor can be accepted.
- desc_addr  in  ADDR_W  descriptor base address.
- desc_len  in  LEN_W  descriptor length in bytes.
- flush  in  1  discard all queued, not-yet-issued descriptors.
- dma_start  out  1  one-cycle start pulse to the DMA.
- dma_base_addr  out  ADDR_W  DMA base address.
- dma_length  out  LEN_W  DMA length.
- dma_done  in  1  DMA completion; may be a pulse or a held level.
- busy  out  1  high when state is not IDLE or the FIFO is non-empty.
- queue_count  out  $clog2(DEPTH)+1  number of FIFO entries.
- done_count  out  CNT_W  completed descriptors; wraps modulo 2^CNT_W.
- all_done  out  1  one-cycle pulse when the queue has drained.

Behaviour:
- Reset (asynchronous, applied at any time, including mid-transfer): state=IDLE; FIFO emptied; dma_start=0; dma_base_addr=0; dma_length=0; done_count=0; all_done=0; internal pending flag=0.
  - After reset, desc_ready=1, busy=0, queue_count=0.
  - An in-flight DMA transfer is abandoned; a dma_done arriving after reset is ignored because the state is IDLE.
- Push rule:
  - desc_ready = (queue_count < DEPTH) && !flush.
  - A descriptor is accepted at an edge where desc_valid && desc_ready.
  - No push is accepted when the FIFO is full, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle are allowed when the FIFO is not full; queue_count is then unchanged.
- flush: at an edge where flush=1, the FIFO is emptied. The active transfer (START/WAIT/RELEASE) continues unaffected. If IDLE would pop at the same edge, flush wins and nothing is popped.
- Moore FSM; dma_start = (state==START):
  - IDLE, FIFO non-empty, no flush: pop the head; register its addr and len into dma_base_addr and dma_length.
    - If len==0: the descriptor is skipped with no DMA activity; done_count+1 and pending=1; stay IDLE.
    - Otherwise go to START.
  - START: lasts exactly one cycle -> WAIT.
  - WAIT: on dma_done=1, done_count+1 and pending=1 -> RELEASE.
  - RELEASE: stay until dma_done=0 -> IDLE. A held dma_done therefore counts exactly once and cannot start the next descriptor early.
- Latency:
  - A descriptor accepted at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1.
  - dma_start is high between edges k+1 and k+2.
  - A pulse-type dma_done seen at edge d gives RELEASE at d and IDLE at d+1; the next descriptor is popped at d+2 at the earliest.
- dma_base_addr and dma_length change only on a pop; they are stable from START through RELEASE.
- all_done: combinational output, high when state==IDLE && queue_count==0 && pending==1. pending clears on that edge, so all_done lasts exactly one cycle.
  - If a push lands at that same edge, the pulse still fires once.
- done_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Single descriptor: addr=0x0, len=32; stub DMA asserts dma_done for 1 cycle, 40 cycles after start -> exactly one dma_start pulse with dma_base_addr=0, dma_length=32; done_count=1; one all_done pulse; busy=0 afterwards.
- Back-pressure: DEPTH=4; push 5 descriptors back-to-back while the DMA stalls -> first is popped, then 4 are queued, desc_ready=0 while queue_count=4. Descriptors are issued in order with addresses 0x00, 0x20, 0x40, 0x60, 0x80; final done_count=5; one all_done pulse.
- Zero length: queue len=0, then len=16 -> no dma_start for the first; done_count steps to 1 immediately; second issues normally; final done_count=2.
- Held done: dma_done held high for 3 cycles with the next descriptor queued -> done_count increments by 1 only; next dma_start only after dma_done falls.
- Flush: 3 queued, 1 active, assert flush for 1 cycle -> queue_count=0; active transfer completes; done_count=1; all_done pulses once.
- Reset mid-transfer: drop rst_n during WAIT with 2 queued -> all outputs return to reset values immediately; a later dma_done pulse causes no count change; a new descriptor after reset issues normally.
